rv32imf_rf_write_arbiter: RTL and testbench
===========================================

# rv32imf_rf_write_arbiter

Write-side front end of the integer/FP register file. It collects results from three producers: the single-cycle ALU, the load/store unit, and the long-latency mult/div/FPU path. It then drives the register file's two write ports with registered address, data and enable. The ALU path goes straight to write port B. The LSU and mult/div/FPU paths are round-robin arbitrated into a small FIFO that drains to write port A. The controller can hold the drain, and can query whether a register has a write still pending.

## Interface
- ADDR_WIDTH, 5, register address width; MSB set selects the FP bank, lower bits select the register index
- DATA_WIDTH, 32, result width
- FIFO_DEPTH, 4, queued LSU/MDFP results; power of two, ≥2
- clk  in  1  clock
- rst_n  in  1  reset; synchronous and active-low
- alu_valid_i / alu_addr_i / alu_data_i  in  1 / ADDR_WIDTH / DATA_WIDTH  ALU result; no backpressure
- lsu_valid_i / lsu_addr_i / lsu_data_i  in  1 / ADDR_WIDTH / DATA_WIDTH  load result
- lsu_ready_o  out  1  load result accepted when valid & ready
- mdfp_valid_i / mdfp_addr_i / mdfp_data_i  in  1 / ADDR_WIDTH / DATA_WIDTH  mult/div/FPU result
- mdfp_ready_o  out  1  mdfp handshake ready
- hold_i  in  1  controller stall; no FIFO pop while high
- chk_addr_i  in  ADDR_WIDTH  pending-write query address
- chk_hit_o  out  1  combinational; a valid FIFO entry or the port-A output register holds chk_addr_i
- waddr_a_o / wdata_a_o / we_a_o  out  ADDR_WIDTH / DATA_WIDTH / 1  register-file write port A
- waddr_b_o / wdata_b_o / we_b_o  out  ADDR_WIDTH / DATA_WIDTH / 1  register-file write port B
- busy_o  out  1  FIFO non-empty or we_a_o high

## Operation
- **Address 0 (x0) suppression**
  - Address all-zero (x0) is never written.
  - ALU x0 results: we_b_o stays low.
  - LSU/MDFP x0 results: the handshake completes but nothing is enqueued.
  - Address 2^(ADDR_WIDTH-1) (f0) is a normal register.
- **ALU path:** each cycle, waddr_b_o/wdata_b_o are loaded from alu_addr_i/alu_data_i, and we_b_o <= alu_valid_i & (alu_addr_i != 0).
- **Arbitration**
  - At most one enqueue per cycle.
  - Readiness:
    - lsu_ready_o = !full & (rr==LSU | !mdfp_valid_i)
    - mdfp_ready_o = !full & (rr==MDFP | !lsu_valid_i)
  - rr toggles only after a handshake in which both producers were valid.
  - Ready depends only on count, rr and the other producer's valid, never on the producer's own valid.
- **FIFO**
  - full = (count == FIFO_DEPTH), from the registered count only; a same-cycle pop does not free space for a push.
  - Count update: count += push − pop.
  - Pointers wrap modulo FIFO_DEPTH.
- **Drain**
  - If !hold_i and the FIFO is non-empty: pop the head into the port-A registers; we_a_o is high next cycle.
  - Otherwise we_a_o is low next cycle; waddr_a_o and wdata_a_o hold their values.
- **Same-cycle collision between ports A and B**
  - Both ports are emitted unchanged.
  - The register file gives port B priority, which is correct: the core scoreboard guarantees the ALU result is younger in program order.
- **chk_hit_o**
  - Covers FIFO entries at indices head..tail-1, plus the port-A output register while we_a_o is high.
  - Excludes address 0.
- **Reset**
  - rst_n low at a clock edge clears count, pointers and rr (rr to LSU).
  - All outputs go to 0: we_a_o, we_b_o, waddr/wdata, busy_o.
  - Queued entries are discarded mid-operation.
  - While rst_n is low, lsu_ready_o and mdfp_ready_o are 0.

## Timing
- ALU: alu_valid_i in cycle t -> we_b_o in cycle t+1.
- LSU/MDFP handshake in cycle t, FIFO empty, hold_i low -> we_a_o in cycle t+2. Minimum latency is 2; there is no bypass.
- Sustained throughput is 1 queued result per cycle.
- hold_i high in cycle t: no pop in t, we_a_o low in t+1.
- Full FIFO with hold_i low: ready is deasserted for one cycle, then reasserts.

## Structure
- Package rv32imf_pkg holds:
  - wb_entry_t struct {addr, data}
  - rr source enum {WB_SRC_LSU, WB_SRC_MDFP}
  - default FIFO depth constant
- Sub-module rv32imf_wb_fifo:
  - Parameterised entry type/width and depth.
  - push/pop, full/empty, count.
  - Exposes its entry array plus valid mask for chk_hit_o.

## Test plan
- ALU at address 3, data 0xDEADBEEF, cycle 10 -> we_b_o=1, waddr_b_o=3, wdata_b_o=0xDEADBEEF at cycle 11. ALU at address 0 -> we_b_o stays 0.
- LSU and MDFP both valid for 4 cycles with addresses 5 and 17 -> grants alternate LSU, MDFP, LSU, MDFP. Port A emits 5, 17, 5, 17 from cycle 2 onward.
- hold_i high while LSU pushes 4 entries -> lsu_ready_o=0 on the fifth cycle, chk_hit_o=1 for each queued address. Release hold -> 4 consecutive we_a_o pulses in order, then busy_o falls.
- LSU result at address 0 -> handshake completes, count unchanged, we_a_o never asserted, chk_addr_i=0 gives chk_hit_o=0.
- ALU and queue head both at address 8 in the same cycle -> we_a_o and we_b_o both high next cycle with waddr 8.
- rst_n low for 1 cycle with 3 queued entries -> next cycle: all outputs 0, busy_o=0. The first subsequent LSU push emits after 2 cycles.

Source files
------------

// File: rtl/rv32imf_pkg.sv
// Shared types and defaults for the register-file write-side arbiter.
package rv32imf_pkg;

  localparam int unsigned WB_ADDR_W     = 5;
  localparam int unsigned WB_DATA_W     = 32;
  localparam int unsigned WB_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_LSU  = 1'b0,
    WB_SRC_MDFP = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rv32imf_wb_fifo.sv
// Circular write-back queue; exposes per-slot key field and occupancy mask for pending-write lookup.
module rv32imf_wb_fifo
  import rv32imf_pkg::*;
#(
  parameter type         entry_t = wb_entry_t,
  parameter int unsigned DEPTH   = WB_FIFO_DEPTH,
  parameter int unsigned TAG_W   = WB_ADDR_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [TAG_W-1:0] tag_o [DEPTH],
  output logic [DEPTH-1:0] valid_o
);

  localparam int unsigned ENTRY_W = $bits(entry_t);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] offset;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Slot i is live when its distance from the head is below the occupancy.
  always_comb begin
    offset  = '0;
    valid_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset     = PTR_W'(i) - rd_ptr;
      valid_o[i] = ({1'b0, offset} < count);
      tag_o[i]   = mem[i][ENTRY_W-1 -: TAG_W];
    end
  end

endmodule

// File: rtl/rv32imf_rf_write_arbiter.sv
// Register-file write front end: ALU straight to port B, LSU/MDFP round-robin queued to port A.
module rv32imf_rf_write_arbiter
  import rv32imf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
  parameter int unsigned DATA_WIDTH = WB_DATA_W,
  parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_addr_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  output logic                  lsu_ready_o,
  input  logic                  mdfp_valid_i,
  input  logic [ADDR_WIDTH-1:0] mdfp_addr_i,
  input  logic [DATA_WIDTH-1:0] mdfp_data_i,
  output logic                  mdfp_ready_o,
  input  logic                  hold_i,
  input  logic [ADDR_WIDTH-1:0] chk_addr_i,
  output logic                  chk_hit_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o,
  output logic                  busy_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  wb_src_e               rr;
  wb_src_e               rr_next;
  logic                  lsu_hs;
  logic                  mdfp_hs;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  entry_t                push_entry;
  entry_t                head_entry;
  logic [ADDR_WIDTH-1:0] fifo_tag [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_valid;
  logic                  hit;

  // Ready never looks at the producer's own valid, only at space, turn and the rival's valid.
  assign lsu_ready_o  = rst_n & ~fifo_full & ((rr == WB_SRC_LSU)  | ~mdfp_valid_i);
  assign mdfp_ready_o = rst_n & ~fifo_full & ((rr == WB_SRC_MDFP) | ~lsu_valid_i);
  assign lsu_hs       = lsu_valid_i & lsu_ready_o;
  assign mdfp_hs      = mdfp_valid_i & mdfp_ready_o;
  assign fifo_pop     = ~hold_i & ~fifo_empty;

  // x0 results complete their handshake but are dropped here.
  always_comb begin
    push_entry = '{addr: lsu_addr_i, data: lsu_data_i};
    fifo_push  = (lsu_hs & (lsu_addr_i != '0)) | (mdfp_hs & (mdfp_addr_i != '0));
    rr_next    = rr;
    if (mdfp_hs) push_entry = '{addr: mdfp_addr_i, data: mdfp_data_i};
    if ((lsu_hs | mdfp_hs) & lsu_valid_i & mdfp_valid_i)
      rr_next = (rr == WB_SRC_LSU) ? WB_SRC_MDFP : WB_SRC_LSU;
  end

  rv32imf_wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH),
    .TAG_W   (ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .tag_o     (fifo_tag),
    .valid_o   (fifo_valid)
  );

  always_comb begin
    hit = we_a_o & (waddr_a_o == chk_addr_i);
    for (int unsigned i = 0; i < FIFO_DEPTH; i++)
      hit = hit | (fifo_valid[i] & (fifo_tag[i] == chk_addr_i));
    chk_hit_o = hit & (chk_addr_i != '0);
  end

  assign busy_o = (fifo_count != '0) | we_a_o;

  // Port A address/data hold when nothing drains; port B reloads every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr        <= WB_SRC_LSU;
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      we_b_o    <= 1'b0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
    end else begin
      rr     <= rr_next;
      we_a_o <= fifo_pop;
      if (fifo_pop) begin
        waddr_a_o <= head_entry.addr;
        wdata_a_o <= head_entry.data;
      end
      we_b_o    <= alu_valid_i & (alu_addr_i != '0);
      waddr_b_o <= alu_addr_i;
      wdata_b_o <= alu_data_i;
    end
  end

endmodule

// File: tb/tb_rv32imf_rf_write_arbiter.sv
// Directed self-checking bench for rv32imf_rf_write_arbiter.
module tb_rv32imf_rf_write_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          lsu_valid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready;
  logic          mdfp_valid;
  logic [AW-1:0] mdfp_addr;
  logic [DW-1:0] mdfp_data;
  logic          mdfp_ready;
  logic          hold;
  logic [AW-1:0] chk_addr;
  logic          chk_hit;
  logic [AW-1:0] waddr_a;
  logic [DW-1:0] wdata_a;
  logic          we_a;
  logic [AW-1:0] waddr_b;
  logic [DW-1:0] wdata_b;
  logic          we_b;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  rv32imf_rf_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid_i  (alu_valid),
    .alu_addr_i   (alu_addr),
    .alu_data_i   (alu_data),
    .lsu_valid_i  (lsu_valid),
    .lsu_addr_i   (lsu_addr),
    .lsu_data_i   (lsu_data),
    .lsu_ready_o  (lsu_ready),
    .mdfp_valid_i (mdfp_valid),
    .mdfp_addr_i  (mdfp_addr),
    .mdfp_data_i  (mdfp_data),
    .mdfp_ready_o (mdfp_ready),
    .hold_i       (hold),
    .chk_addr_i   (chk_addr),
    .chk_hit_o    (chk_hit),
    .waddr_a_o    (waddr_a),
    .wdata_a_o    (wdata_a),
    .we_a_o       (we_a),
    .waddr_b_o    (waddr_b),
    .wdata_b_o    (wdata_b),
    .we_b_o       (we_b),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    lsu_valid = 1'b1;
    mdfp_valid = 1'b1;
    #1;
    n_cmp++;
    if (lsu_ready !== 1'b0 || mdfp_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ready: got lsu=%0b mdfp=%0b expected 0 0", lsu_ready, mdfp_ready);
    end
    lsu_valid = 1'b0;
    mdfp_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({we_a, we_b, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_en: got we_a/we_b/busy=%b expected 000", {we_a, we_b, busy});
    end
    n_cmp++;
    if (waddr_a !== 5'd0 || wdata_a !== 32'd0 || waddr_b !== 5'd0 || wdata_b !== 32'd0) begin
      n_err++;
      $display("FAIL rst_addr_data: got a=%0h/%0h b=%0h/%0h expected all 0", waddr_a, wdata_a, waddr_b, wdata_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu;
    alu_valid = 1'b1;
    alu_addr = 5'd3;
    alu_data = 32'hDEAD_BEEF;
    tick();
    n_cmp++;
    if (we_b !== 1'b1 || waddr_b !== 5'd3 || wdata_b !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL alu_write: got we=%0b addr=%0d data=%h expected 1 3 deadbeef", we_b, waddr_b, wdata_b);
    end
    alu_addr = 5'd0;
    alu_data = 32'h1234_5678;
    tick();
    n_cmp++;
    if (we_b !== 1'b0) begin
      n_err++;
      $display("FAIL alu_x0: got we_b=%0b expected 0", we_b);
    end
    alu_addr = 5'd16;
    alu_data = 32'h0000_00F0;
    tick();
    n_cmp++;
    if (we_b !== 1'b1 || waddr_b !== 5'd16) begin
      n_err++;
      $display("FAIL alu_f0: got we=%0b addr=%0d expected 1 16", we_b, waddr_b);
    end
    alu_valid = 1'b0;
    tick();
  endtask

  task automatic test_arbitration;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    lsu_addr = 5'd5;
    lsu_data = 32'h0000_0105;
    mdfp_addr = 5'd17;
    mdfp_data = 32'h0000_0211;
    for (int k = 0; k < 7; k++) begin
      lsu_valid = (k < 4);
      mdfp_valid = (k < 4);
      #1;
      if (k < 4) begin
        n_cmp++;
        if (lsu_ready !== (k % 2 == 0) || mdfp_ready !== (k % 2 == 1)) begin
          n_err++;
          $display("FAIL rr_grant k=%0d: got lsu=%0b mdfp=%0b expected %0b %0b",
                   k, lsu_ready, mdfp_ready, (k % 2 == 0), (k % 2 == 1));
        end
      end
      exp_we   = (k >= 2 && k < 6);
      exp_addr = (k % 2 == 0) ? 5'd5 : 5'd17;
      exp_data = (k % 2 == 0) ? 32'h0000_0105 : 32'h0000_0211;
      n_cmp++;
      if (we_a !== exp_we || (exp_we && (waddr_a !== exp_addr || wdata_a !== exp_data))) begin
        n_err++;
        $display("FAIL rr_port_a k=%0d: got we=%0b addr=%0d data=%h expected %0b %0d %h",
                 k, we_a, waddr_a, wdata_a, exp_we, exp_addr, exp_data);
      end
      if (k == 6) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL rr_idle_busy: got %0b expected 0", busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold_full;
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      lsu_valid = 1'b1;
      lsu_addr = AW'(9 + k);
      lsu_data = DW'(32'hA0 + k);
      #1;
      n_cmp++;
      if (lsu_ready !== (k < 4)) begin
        n_err++;
        $display("FAIL hold_ready k=%0d: got %0b expected %0b", k, lsu_ready, (k < 4));
      end
      if (k < 4) tick();
    end
    lsu_valid = 1'b0;
    n_cmp++;
    if (we_a !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL hold_state: got we_a=%0b busy=%0b expected 0 1", we_a, busy);
    end
    for (int a = 9; a < 14; a++) begin
      chk_addr = AW'(a);
      #1;
      n_cmp++;
      if (chk_hit !== (a < 13)) begin
        n_err++;
        $display("FAIL hold_chk addr=%0d: got %0b expected %0b", a, chk_hit, (a < 13));
      end
    end
    chk_addr = 5'd0;
    hold = 1'b0;
    #1;
    n_cmp++;
    if (lsu_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready: got %0b expected 0", lsu_ready);
    end
    tick();
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (we_a !== 1'b1 || waddr_a !== AW'(9 + j) || wdata_a !== DW'(32'hA0 + j)) begin
        n_err++;
        $display("FAIL drain j=%0d: got we=%0b addr=%0d data=%h expected 1 %0d %h",
                 j, we_a, waddr_a, wdata_a, 9 + j, 32'hA0 + j);
      end
      if (j == 0) begin
        n_cmp++;
        if (lsu_ready !== 1'b1) begin
          n_err++;
          $display("FAIL full_reready: got %0b expected 1", lsu_ready);
        end
      end
      tick();
    end
    n_cmp++;
    if (we_a !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drain_done: got we_a=%0b busy=%0b expected 0 0", we_a, busy);
    end
  endtask

  task automatic test_x0;
    lsu_valid = 1'b1;
    lsu_addr = 5'd0;
    lsu_data = 32'h0000_0055;
    #1;
    n_cmp++;
    if (lsu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL x0_ready: got %0b expected 1", lsu_ready);
    end
    tick();
    lsu_valid = 1'b0;
    chk_addr = 5'd0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || chk_hit !== 1'b0) begin
      n_err++;
      $display("FAIL x0_queue: got busy=%0b hit=%0b expected 0 0", busy, chk_hit);
    end
    tick();
    tick();
    n_cmp++;
    if (we_a !== 1'b0) begin
      n_err++;
      $display("FAIL x0_we_a: got %0b expected 0", we_a);
    end
  endtask

  task automatic test_collision;
    lsu_valid = 1'b1;
    lsu_addr = 5'd8;
    lsu_data = 32'h0000_008A;
    tick();
    lsu_valid = 1'b0;
    alu_valid = 1'b1;
    alu_addr = 5'd8;
    alu_data = 32'h0000_008B;
    tick();
    alu_valid = 1'b0;
    chk_addr = 5'd8;
    #1;
    n_cmp++;
    if (we_a !== 1'b1 || waddr_a !== 5'd8 || wdata_a !== 32'h8A) begin
      n_err++;
      $display("FAIL coll_a: got we=%0b addr=%0d data=%h expected 1 8 8a", we_a, waddr_a, wdata_a);
    end
    n_cmp++;
    if (we_b !== 1'b1 || waddr_b !== 5'd8 || wdata_b !== 32'h8B) begin
      n_err++;
      $display("FAIL coll_b: got we=%0b addr=%0d data=%h expected 1 8 8b", we_b, waddr_b, wdata_b);
    end
    n_cmp++;
    if (chk_hit !== 1'b1) begin
      n_err++;
      $display("FAIL coll_chk: got %0b expected 1", chk_hit);
    end
    chk_addr = 5'd0;
    tick();
  endtask

  task automatic test_reset_midop;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lsu_valid = 1'b1;
      lsu_addr = AW'(20 + k);
      lsu_data = DW'(32'h200 + k);
      tick();
    end
    lsu_valid = 1'b0;
    chk_addr = 5'd20;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || chk_hit !== 1'b1) begin
      n_err++;
      $display("FAIL mid_queued: got busy=%0b hit=%0b expected 1 1", busy, chk_hit);
    end
    alu_valid = 1'b1;
    alu_addr = 5'd7;
    alu_data = 32'h77;
    lsu_valid = 1'b1;
    lsu_addr = 5'd24;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (lsu_ready !== 1'b0 || mdfp_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_ready: got lsu=%0b mdfp=%0b expected 0 0", lsu_ready, mdfp_ready);
    end
    tick();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    n_cmp++;
    if ({we_a, we_b, busy, chk_hit} !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_rst_flags: got we_a/we_b/busy/hit=%b expected 0000", {we_a, we_b, busy, chk_hit});
    end
    n_cmp++;
    if (waddr_a !== 5'd0 || wdata_a !== 32'd0 || waddr_b !== 5'd0 || wdata_b !== 32'd0) begin
      n_err++;
      $display("FAIL mid_rst_data: got a=%0h/%0h b=%0h/%0h expected all 0", waddr_a, wdata_a, waddr_b, wdata_b);
    end
    rst_n = 1'b1;
    hold = 1'b0;
    chk_addr = 5'd0;
    lsu_valid = 1'b1;
    lsu_addr = 5'd23;
    lsu_data = 32'h123;
    tick();
    lsu_valid = 1'b0;
    n_cmp++;
    if (we_a !== 1'b0) begin
      n_err++;
      $display("FAIL post_rst_early: got we_a=%0b expected 0", we_a);
    end
    tick();
    n_cmp++;
    if (we_a !== 1'b1 || waddr_a !== 5'd23 || wdata_a !== 32'h123) begin
      n_err++;
      $display("FAIL post_rst_emit: got we=%0b addr=%0d data=%h expected 1 23 123", we_a, waddr_a, wdata_a);
    end
    tick();
    n_cmp++;
    if (we_a !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_rst_idle: got we_a=%0b busy=%0b expected 0 0", we_a, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0;
    alu_addr = '0;
    alu_data = '0;
    lsu_valid = 1'b0;
    lsu_addr = '0;
    lsu_data = '0;
    mdfp_valid = 1'b0;
    mdfp_addr = '0;
    mdfp_data = '0;
    hold = 1'b0;
    chk_addr = '0;
    tick();
    test_reset();
    test_alu();
    test_arbitration();
    test_hold_full();
    test_x0();
    test_collision();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
